kband_out_fifo_wn: RTL

//  Single-clock, parametrised wide-to-narrow FIFO for the KBand result path: accepts WIDE_W-bit

---
 rtl/kband_pkg.sv | 33 +++
 rtl/kband_lane_sel.sv | 38 +++
 rtl/kband_out_fifo_wn.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/kband_pkg.sv
// ============================================================================
// Module  : kband_pkg
// Brief   : Shared constants, lane-order enum and width helpers for the KBand
//           result-path FIFO.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package kband_pkg;

    localparam int KBAND_WIDE_W   = 4096;
    localparam int KBAND_NARROW_W = 128;
    localparam int KBAND_DEPTH    = 4;

    typedef enum logic {
        LANE_LSB_FIRST = 1'b0,
        LANE_MSB_FIRST = 1'b1
    } lane_order_e;

    function automatic int ratio(input int wide_w, input int narrow_w);
        return wide_w / narrow_w;
    endfunction

    function automatic int usedw_w(input int max_count);
        return $clog2(max_count + 1);
    endfunction

    localparam int KBAND_WUSEDW_W = usedw_w(KBAND_DEPTH);
    localparam int KBAND_RUSEDW_W = usedw_w(KBAND_DEPTH * ratio(KBAND_WIDE_W, KBAND_NARROW_W));

endpackage

`default_nettype wire

// File: rtl/kband_lane_sel.sv
// ============================================================================
// Module  : kband_lane_sel
// Brief   : Combinational RATIO:1 lane multiplexer; maps the read lane counter
//           onto a narrow slice of the wide entry according to lane order.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module kband_lane_sel
    import kband_pkg::*;
#(
    parameter int WIDE_W    = KBAND_WIDE_W,
    parameter int NARROW_W  = KBAND_NARROW_W,
    parameter int MSB_FIRST = 1,
    parameter int LANE_W    = 5
) (
    input  logic [WIDE_W-1:0]   i_data,
    input  logic [LANE_W-1:0]   i_lane,
    output logic [NARROW_W-1:0] o_q
);

    localparam int          c_RATIO = WIDE_W / NARROW_W;
    localparam lane_order_e c_ORDER = (MSB_FIRST != 0) ? LANE_MSB_FIRST : LANE_LSB_FIRST;

    logic [LANE_W-1:0] w_sel;

    always_comb begin
        if (c_ORDER == LANE_MSB_FIRST) begin
            w_sel = LANE_W'(c_RATIO - 1) - i_lane;
        end else begin
            w_sel = i_lane;
        end
        o_q = i_data[w_sel*NARROW_W +: NARROW_W];
    end

endmodule

`default_nettype wire

// File: rtl/kband_out_fifo_wn.sv
// ============================================================================
// Module  : kband_out_fifo_wn
// Brief   : Single-clock wide-to-narrow show-ahead FIFO for the KBand result
//           path. Optional statistics enabled by KBAND_OUT_FIFO_STATS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module kband_out_fifo_wn
    import kband_pkg::*;
#(
    parameter int WIDE_W    = KBAND_WIDE_W,
    parameter int NARROW_W  = KBAND_NARROW_W,
    parameter int DEPTH     = KBAND_DEPTH,
    parameter int MSB_FIRST = 1
) (
    input  logic                                          clk,
    input  logic                                          aclr_n,
    input  logic                                          flush,
    input  logic [WIDE_W-1:0]                             data,
    input  logic                                          wrreq,
    input  logic                                          rdreq,
    output logic [NARROW_W-1:0]                           q,
    output logic [$clog2(DEPTH+1)-1:0]                    wrusedw,
    output logic [$clog2(DEPTH*(WIDE_W/NARROW_W)+1)-1:0]  rdusedw,
    output logic                                          rdempty,
`ifdef KBAND_OUT_FIFO_STATS_EN
    output logic                                          wrfull,
    output logic                                          ovf_sticky,
    output logic                                          unf_sticky,
    output logic [$clog2(DEPTH+1)-1:0]                    peak_usedw
`else
    output logic                                          wrfull
`endif
);

    localparam int c_RATIO = ratio(WIDE_W, NARROW_W);
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_LW    = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
    localparam int c_WUW   = $clog2(DEPTH + 1);
    localparam int c_RUW   = $clog2(DEPTH * c_RATIO + 1);

    if ((WIDE_W % NARROW_W) != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("kband_out_fifo_wn: WIDE_W must be a multiple of NARROW_W and DEPTH a power of 2 >= 2");
    end

    logic [WIDE_W-1:0]   r_mem [DEPTH];
    logic [c_AW:0]       r_wr_ptr;
    logic [c_AW:0]       r_rd_ptr;
    logic [c_LW-1:0]     r_lane;

    logic [c_AW:0]       w_used;
    logic                w_wr;
    logic                w_rd;
    logic                w_last;
    logic [NARROW_W-1:0] w_q;

    // All flags derive from registered state only, so no request reaches an output combinationally.
    always_comb begin
        w_used  = r_wr_ptr - r_rd_ptr;
        wrusedw = c_WUW'(w_used);
        rdusedw = c_RUW'(w_used) * c_RUW'(c_RATIO) - c_RUW'(r_lane);
        rdempty = (w_used == '0);
        wrfull  = (w_used == (c_AW+1)'(DEPTH));
        w_last  = (r_lane == c_LW'(c_RATIO - 1));
        w_wr    = wrreq && !wrfull && !flush;
        w_rd    = rdreq && !rdempty && !flush;
        q       = rdempty ? '0 : w_q;
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= data;
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_lane   <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_lane   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                if (w_last) begin
                    r_lane   <= '0;
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end else begin
                    r_lane   <= r_lane + 1'b1;
                end
            end
        end
    end

    kband_lane_sel #(
        .WIDE_W    (WIDE_W),
        .NARROW_W  (NARROW_W),
        .MSB_FIRST (MSB_FIRST),
        .LANE_W    (c_LW)
    ) u_lane_sel (
        .i_data (r_mem[r_rd_ptr[c_AW-1:0]]),
        .i_lane (r_lane),
        .o_q    (w_q)
    );

`ifdef KBAND_OUT_FIFO_STATS_EN
    logic             r_ovf;
    logic             r_unf;
    logic [c_WUW-1:0] r_peak;
    logic [c_WUW-1:0] w_used_nxt;

    // Peak tracks the occupancy that will be visible after this edge.
    always_comb begin
        w_used_nxt = c_WUW'(w_used) + c_WUW'(w_wr) - c_WUW'(w_rd && w_last);
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_peak <= '0;
        end else if (flush) begin
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_peak <= '0;
        end else begin
            r_ovf <= r_ovf | (wrreq && wrfull);
            r_unf <= r_unf | (rdreq && rdempty);
            if (w_used_nxt > r_peak) begin
                r_peak <= w_used_nxt;
            end
        end
    end

    assign ovf_sticky = r_ovf;
    assign unf_sticky = r_unf;
    assign peak_usedw = r_peak;
`endif

endmodule

`default_nettype wire
